// File: rtl/product_accumulator.sv
// Frame accumulator: sums a programmable number of signed products into an AW-bit total.
// Optional saturation on overflow when PRODUCT_ACC_SAT_EN is defined (default: wrap).
module product_accumulator #(
  parameter int PW = 32,
  parameter int AW = 40,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic [CW-1:0] i_len,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [PW-1:0] i_in_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [AW-1:0] o_out_data,
  output logic          o_out_ovf
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t        r_state;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_len_q;
  logic          r_ovf;
  logic          r_out_valid;

  logic [AW-1:0] w_ext;
  logic [AW-1:0] w_sum;
  logic [AW-1:0] w_acc_next;
  logic [CW-1:0] w_len_eff;
  logic [CW-1:0] w_count_inc;
  logic          w_ovf;

  assign w_ext       = AW'($signed(i_in_data));
  assign w_sum       = r_acc + w_ext;
  assign w_ovf       = (r_acc[AW-1] == w_ext[AW-1]) && (w_sum[AW-1] != r_acc[AW-1]);
  assign w_len_eff   = (i_len == '0) ? CW'(1) : i_len;
  assign w_count_inc = r_count + CW'(1);

`ifdef PRODUCT_ACC_SAT_EN
  // Clamp toward the common operand sign; later additions continue from the clamp.
  assign w_acc_next = !w_ovf        ? w_sum :
                      r_acc[AW-1]   ? {1'b1, {(AW-1){1'b0}}} :
                                      {1'b0, {(AW-1){1'b1}}};
`else
  assign w_acc_next = w_sum;
`endif

  assign o_in_ready  = (r_state != HOLD) & ~i_clr;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_acc;
  assign o_out_ovf   = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_len_q     <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (i_clr) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_acc   <= w_ext;
            r_count <= CW'(1);
            r_len_q <= w_len_eff;
            r_ovf   <= 1'b0;
            if (w_len_eff == CW'(1)) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ACC;
            end
          end
        end
        ACC: begin
          if (i_in_valid) begin
            r_acc   <= w_acc_next;
            r_count <= w_count_inc;
            r_ovf   <= r_ovf | w_ovf;
            if (w_count_inc == r_len_q) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (i_out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed test of product_accumulator: 40-bit instance plus a 34-bit instance for overflow.
module tb_product_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [7:0]  len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [39:0] out_data;
  logic        out_ovf;

  logic        in_ready34;
  logic        out_valid34;
  logic [33:0] out_data34;
  logic        out_ovf34;

  int errors = 0;
  int checks = 0;

  product_accumulator #(.PW(32), .AW(40), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_len(len),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_ovf(out_ovf)
  );

  product_accumulator #(.PW(32), .AW(34), .CW(8)) dut34 (
    .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_len(len),
    .i_in_valid(in_valid), .o_in_ready(in_ready34), .i_in_data(in_data),
    .o_out_valid(out_valid34), .i_out_ready(out_ready),
    .o_out_data(out_data34), .o_out_ovf(out_ovf34)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; len = 8'd0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b expected 0", out_valid); end
    checks++; if (out_data !== 40'd0) begin errors++; $display("FAIL reset_out_data got %0d expected 0", out_data); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %0b expected 0", out_ovf); end
    $display("reset done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    vals[0] = 32'd8; vals[1] = 32'd2; vals[2] = 32'd8; vals[3] = 32'd2;
    len = 8'd4; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid[%0d] got %0b expected 0", i, out_valid); end
      end
      in_valid = 1'b1; in_data = vals[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0b expected 1", out_valid); end
    checks++; if (out_data !== 40'd20) begin errors++; $display("FAIL b2b_data got %0d expected 20", out_data); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %0b expected 0", out_ovf); end
    $display("frame b2b total=%0d", $signed(out_data));
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_one_cycle got %0b expected 0", out_valid); end
  endtask

  task automatic test_gaps_stall();
    logic [39:0] exp_data;
    exp_data = -40'sd57;
    len = 8'd3; out_ready = 1'b0;
    in_valid = 1'b1; in_data = -32'sd100;
    @(negedge clk); in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk); in_valid = 1'b1; in_data = 32'sd50;
    @(negedge clk); in_data = -32'sd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %0b expected 1", i, out_valid); end
      checks++; if (out_data !== exp_data) begin errors++; $display("FAIL stall_data[%0d] got %0d expected -57", i, $signed(out_data)); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %0b expected 0", i, in_ready); end
      in_valid = 1'b1; in_data = 32'd999;
    end
    $display("frame gaps total=%0d", $signed(out_data));
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid got %0b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_in_ready got %0b expected 1", in_ready); end
  endtask

  task automatic test_len0_len1();
    out_ready = 1'b1;
    for (int l = 0; l < 2; l++) begin
      len = 8'(l); in_valid = 1'b1; in_data = 32'h7FFF_FFFF;
      @(negedge clk); in_valid = 1'b0; len = 8'd9;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL len%0d_valid got %0b expected 1", l, out_valid); end
      checks++; if (out_data !== 40'd2147483647) begin errors++; $display("FAIL len%0d_data got %0d expected 2147483647", l, out_data); end
      $display("frame len=%0d total=%0d", l, $signed(out_data));
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL len%0d_done got %0b expected 0", l, out_valid); end
    end
  endtask

  task automatic test_overflow();
    logic [33:0] exp34;
`ifdef PRODUCT_ACC_SAT_EN
    exp34 = 34'h1_FFFF_FFFF;
`else
    exp34 = 34'h3_7FFF_FF01;
`endif
    len = 8'd255; out_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      in_valid = 1'b1; in_data = 32'h7FFF_FFFF;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf40_valid got %0b expected 1", out_valid); end
    checks++; if (out_data !== 40'h7F_7FFF_FF01) begin errors++; $display("FAIL ovf40_data got %0h expected 7f7fffff01", out_data); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL ovf40_flag got %0b expected 0", out_ovf); end
    checks++; if (out_valid34 !== 1'b1) begin errors++; $display("FAIL ovf34_valid got %0b expected 1", out_valid34); end
    checks++; if (out_data34 !== exp34) begin errors++; $display("FAIL ovf34_data got %0h expected %0h", out_data34, exp34); end
    checks++; if (out_ovf34 !== 1'b1) begin errors++; $display("FAIL ovf34_flag got %0b expected 1", out_ovf34); end
    $display("frame ovf total40=%0h total34=%0h ovf34=%0b", out_data, out_data34, out_ovf34);
    @(negedge clk);
  endtask

  task automatic test_clear();
    len = 8'd4; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'd5;
    @(negedge clk); in_data = 32'd6;
    @(negedge clk); in_data = 32'd77; clr = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready got %0b expected 0", in_ready); end
    @(negedge clk); clr = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %0b expected 0", out_valid); end
    checks++; if (out_data !== 40'd0) begin errors++; $display("FAIL clr_data got %0d expected 0", out_data); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'd1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_frame_valid got %0b expected 1", out_valid); end
    checks++; if (out_data !== 40'd4) begin errors++; $display("FAIL clr_frame_data got %0d expected 4", out_data); end
    $display("frame after clr total=%0d", $signed(out_data));
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    len = 8'd2; out_ready = 1'b0;
    in_valid = 1'b1; in_data = -32'sd3;
    @(negedge clk); in_data = -32'sd4;
    @(negedge clk); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %0b expected 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b expected 0", out_valid); end
    checks++; if (out_data !== 40'd0) begin errors++; $display("FAIL arst_data got %0d expected 0", out_data); end
    checks++; if (out_ovf34 !== 1'b0) begin errors++; $display("FAIL arst_ovf got %0b expected 0", out_ovf34); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready got %0b expected 1", in_ready); end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    $display("async reset done");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps_stall();
    test_len0_len1();
    test_overflow();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
